// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared constants for the operand-select pipeline stage:
//                default data width and the stage occupancy encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default data width of a selectable operand
    localparam int PIPE_WIDTH = 32;

    // Stage occupancy: nothing held, main register full, main and skid full
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_mux_sel.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mux_sel
//  Description : Purely combinational NUM_IN:1 operand selector. An
//                out-of-range select returns source 0 and flags oErr.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mux_sel
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = PIPE_WIDTH,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] iData,
    input  logic [SEL_W-1:0]        iSel,
    output logic [WIDTH-1:0]        oData,
    output logic                    oErr
);

    // Binary select over the flattened sources; any code with no matching
    // source keeps the source-0 / error defaults.
    always_comb begin
        oData = iData[WIDTH-1:0];
        oErr  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (iSel == SEL_W'(k)) begin
                oData = iData[k*WIDTH +: WIDTH];
                oErr  = 1'b0;
            end
        end
    end

endmodule : pipe_mux_sel
`default_nettype wire

// File: rtl/pipe_mux_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_mux_stage
//  Description : Operand-select pipeline stage. Selects one of NUM_IN sources
//                and registers it behind a valid/ready handshake with a
//                two-entry skid buffer (main + skid) so that oReady is a pure
//                register output. Supports synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_mux_stage
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = PIPE_WIDTH,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic [NUM_IN*WIDTH-1:0] iData,
    input  logic [SEL_W-1:0]        iSel,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic                    iFlush,
    output logic [WIDTH-1:0]        oData,
    output logic                    oErr,
    output logic                    oValid,
    input  logic                    iReady
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;
    logic             w_accept;
    logic             w_pop;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             valid_q;
    logic             ready_q;
    logic [WIDTH-1:0] main_data_q;
    logic             main_err_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             skid_err_q;

    logic             w_load_main;
    logic             w_load_skid;
    logic             w_main_from_skid;

    pipe_mux_sel #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .iData (iData),
        .iSel  (iSel),
        .oData (w_sel_data),
        .oErr  (w_sel_err)
    );

    assign w_accept = iValid && ready_q && !iFlush;
    assign w_pop    = valid_q && iReady;

    // Occupancy transitions and register load enables; flush wins over all
    always_comb begin
        state_d          = state_q;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_load_main = 1'b1;
                    state_d     = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_load_skid = 1'b1;
                    state_d     = ST_TWO;
                end else if (w_pop) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_main_from_skid = 1'b1;
                    state_d          = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (iFlush) begin
            state_d          = ST_EMPTY;
            w_load_main      = 1'b0;
            w_load_skid      = 1'b0;
            w_main_from_skid = 1'b0;
        end
    end

    // State, registered handshake outputs and the two data entries
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            ready_q <= (state_d != ST_TWO);
            if (w_load_main) begin
                main_data_q <= w_sel_data;
                main_err_q  <= w_sel_err;
            end else if (w_main_from_skid) begin
                main_data_q <= skid_data_q;
                main_err_q  <= skid_err_q;
            end
            if (w_load_skid) begin
                skid_data_q <= w_sel_data;
                skid_err_q  <= w_sel_err;
            end
        end
    end

    assign oData  = main_data_q;
    assign oErr   = main_err_q;
    assign oValid = valid_q;
    assign oReady = ready_q;

endmodule : pipe_mux_stage
`default_nettype wire

// File: tb/tb_pipe_mux_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_mux_stage
//  Description : Self-checking bench for pipe_mux_stage (NUM_IN=4 main
//                instance with scoreboard, NUM_IN=3 instance for
//                out-of-range select).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mux_stage;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
    } beat_t;

    logic           iClk;
    logic           iRst_n;
    logic [4*W-1:0] iData;
    logic [1:0]     iSel;
    logic           iValid;
    logic           oReady;
    logic           iFlush;
    logic [W-1:0]   oData;
    logic           oErr;
    logic           oValid;
    logic           iReady;

    logic [3*W-1:0] d3_iData;
    logic [1:0]     d3_iSel;
    logic           d3_iValid;
    logic           d3_oReady;
    logic           d3_iFlush;
    logic [W-1:0]   d3_oData;
    logic           d3_oErr;
    logic           d3_oValid;
    logic           d3_iReady;

    int    checks;
    int    errors;
    beat_t sb[$];

    pipe_mux_stage #(.WIDTH(W), .NUM_IN(4)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iData  (iData),
        .iSel   (iSel),
        .iValid (iValid),
        .oReady (oReady),
        .iFlush (iFlush),
        .oData  (oData),
        .oErr   (oErr),
        .oValid (oValid),
        .iReady (iReady)
    );

    pipe_mux_stage #(.WIDTH(W), .NUM_IN(3)) dut3 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iData  (d3_iData),
        .iSel   (d3_iSel),
        .iValid (d3_iValid),
        .oReady (d3_oReady),
        .iFlush (d3_iFlush),
        .oData  (d3_oData),
        .oErr   (d3_oErr),
        .oValid (d3_oValid),
        .iReady (d3_iReady)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    // Reference selection for a 4-source stage
    function automatic beat_t model4(input logic [4*W-1:0] d, input logic [1:0] s);
        beat_t b;
        b.data = d[int'(s)*W +: W];
        b.err  = 1'b0;
        return b;
    endfunction

    // Scoreboard: compare each downstream pop, then record the accepted beat
    always @(negedge iClk) begin
        beat_t exp_b;
        if (!iRst_n) begin
            sb.delete();
        end else begin
            if (oValid && iReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_beat: got data=%h err=%b, required no beat", oData, oErr);
                end else begin
                    exp_b = sb.pop_front();
                    if (oData !== exp_b.data || oErr !== exp_b.err) begin
                        errors++;
                        $display("FAIL sb_beat: got data=%h err=%b, required data=%h err=%b",
                                 oData, oErr, exp_b.data, exp_b.err);
                    end
                end
            end
            if (iFlush)
                sb.delete();
            else if (iValid && oReady)
                sb.push_back(model4(iData, iSel));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [W-1:0] v);
        iData[k*W +: W] = v;
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        iValid = 1'b1;
        iReady = 1'b1;
        iFlush = 1'b0;
        iSel   = 2'd2;
        iData  = '0;
        set_src(2, 32'hDEAD_BEEF);
        repeat (2) cycle();
        checks++;
        if (oValid !== 1'b0 || oData !== '0 || oErr !== 1'b0 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: got v=%b d=%h e=%b r=%b, required v=0 d=0 e=0 r=1",
                     oValid, oData, oErr, oReady);
        end
        iRst_n = 1'b1;
        cycle();
        checks++;
        if (oValid !== 1'b1 || oData !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_first_beat: got v=%b d=%h, required v=1 d=deadbeef", oValid, oData);
        end
        iValid = 1'b0;
        cycle();
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 4; k++) set_src(k, 32'h1000 + k);
        iReady = 1'b1;
        iValid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            iSel = 2'(i % 4);
            cycle();
            checks++;
            if (oValid !== 1'b1 || oData !== (32'h1000 + (i % 4)) || oReady !== 1'b1) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b d=%h r=%b, required v=1 d=%h r=1",
                         i, oValid, oData, oReady, 32'h1000 + (i % 4));
            end
        end
        iValid = 1'b0;
        cycle();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b, required v=0", oValid);
        end
    endtask

    task automatic test_backpressure();
        set_src(1, 32'hAAAA_0001);
        set_src(2, 32'hBBBB_0002);
        iReady = 1'b0;
        iValid = 1'b1;
        iSel   = 2'd1;
        cycle();
        checks++;
        if (oValid !== 1'b1 || oData !== 32'hAAAA_0001 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got v=%b d=%h r=%b, required v=1 d=aaaa0001 r=1", oValid, oData, oReady);
        end
        iSel = 2'd2;
        cycle();
        checks++;
        if (oReady !== 1'b0 || oData !== 32'hAAAA_0001) begin
            errors++;
            $display("FAIL bp_full: got r=%b d=%h, required r=0 d=aaaa0001", oReady, oData);
        end
        iValid = 1'b0;
        cycle();
        checks++;
        if (oReady !== 1'b0 || oData !== 32'hAAAA_0001 || oValid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got v=%b r=%b d=%h, required v=1 r=0 d=aaaa0001", oValid, oReady, oData);
        end
        iReady = 1'b1;
        #1;
        checks++;
        if (oReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_comb_ready: got r=%b, required r=0", oReady);
        end
        cycle();
        checks++;
        if (oValid !== 1'b1 || oData !== 32'hBBBB_0002 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL bp_second: got v=%b d=%h r=%b, required v=1 d=bbbb0002 r=1", oValid, oData, oReady);
        end
        cycle();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got v=%b, required v=0", oValid);
        end
    endtask

    task automatic test_flush();
        set_src(0, 32'h0000_0A0A);
        set_src(3, 32'h0000_0BAD);
        iReady = 1'b0;
        iValid = 1'b1;
        iSel   = 2'd0;
        repeat (2) cycle();
        checks++;
        if (oReady !== 1'b0) begin
            errors++;
            $display("FAIL flush_setup_two: got r=%b, required r=0", oReady);
        end
        iSel   = 2'd3;
        iFlush = 1'b1;
        cycle();
        checks++;
        if (oValid !== 1'b0 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: got v=%b r=%b, required v=0 r=1", oValid, oReady);
        end
        iFlush = 1'b0;
        iValid = 1'b0;
        iReady = 1'b1;
        repeat (2) cycle();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_ghost: got v=%b d=%h, required v=0", oValid, oData);
        end
    endtask

    task automatic test_async_reset();
        set_src(1, 32'h1234_5678);
        iReady = 1'b0;
        iValid = 1'b1;
        iSel   = 2'd1;
        cycle();
        iValid = 1'b0;
        checks++;
        if (oValid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: got v=%b, required v=1", oValid);
        end
        #2;
        iRst_n = 1'b0;
        #1;
        checks++;
        if (oValid !== 1'b0 || oData !== '0 || oErr !== 1'b0 || oReady !== 1'b1) begin
            errors++;
            $display("FAIL areset_immediate: got v=%b d=%h e=%b r=%b, required v=0 d=0 e=0 r=1",
                     oValid, oData, oErr, oReady);
        end
        cycle();
        iRst_n = 1'b1;
        iReady = 1'b1;
        cycle();
        checks++;
        if (oValid !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: got v=%b, required v=0", oValid);
        end
    endtask

    task automatic test_out_of_range();
        d3_iData  = {32'h0000_0022, 32'h0000_0011, 32'h0000_0005};
        d3_iReady = 1'b1;
        d3_iValid = 1'b1;
        d3_iSel   = 2'd3;
        cycle();
        checks++;
        if (d3_oValid !== 1'b1 || d3_oData !== 32'h5 || d3_oErr !== 1'b1) begin
            errors++;
            $display("FAIL oor_sel3: got v=%b d=%h e=%b, required v=1 d=5 e=1", d3_oValid, d3_oData, d3_oErr);
        end
        d3_iSel = 2'd1;
        cycle();
        checks++;
        if (d3_oData !== 32'h11 || d3_oErr !== 1'b0) begin
            errors++;
            $display("FAIL oor_sel1: got d=%h e=%b, required d=11 e=0", d3_oData, d3_oErr);
        end
        d3_iSel = 2'd2;
        cycle();
        checks++;
        if (d3_oData !== 32'h22 || d3_oErr !== 1'b0) begin
            errors++;
            $display("FAIL oor_sel2: got d=%h e=%b, required d=22 e=0", d3_oData, d3_oErr);
        end
        d3_iValid = 1'b0;
        cycle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            iData  = {$urandom, $urandom, $urandom, $urandom};
            iSel   = 2'($urandom_range(0, 3));
            iValid = 1'($urandom_range(0, 1));
            iReady = ($urandom_range(0, 3) != 0);
            iFlush = ($urandom_range(0, 15) == 0);
            cycle();
        end
        iValid = 1'b0;
        iFlush = 1'b0;
        iReady = 1'b1;
        repeat (4) cycle();
        checks++;
        if (sb.size() != 0 || oValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got queued=%0d v=%b, required queued=0 v=0", sb.size(), oValid);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        d3_iData  = '0;
        d3_iSel   = 2'd0;
        d3_iValid = 1'b0;
        d3_iFlush = 1'b0;
        d3_iReady = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_out_of_range();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_mux_stage
`default_nettype wire

// File: doc/pipe_mux_stage.md
# pipe_mux_stage

Parametrised N-input operand-select pipeline stage: selects one of NUM_IN WIDTH-bit sources and registers the result behind a valid/ready handshake with a 2-entry skid buffer. It replaces the bare 2:1 datapath mux wherever a selected operand crosses a pipeline boundary, e.g. ID→EX forwarding. It adds stall tolerance without combinational ready paths, a synchronous flush, and out-of-range select detection.

## Interface
- WIDTH, 32, data width in bits
- NUM_IN, 4, number of selectable sources, ≥2
- SEL_W, $clog2(NUM_IN), select width; localparam, not overridable
- iClk  input  1  clock; all state updates on the rising edge
- iRst_n  input  1  reset, asynchronous, active-low
- iData  input  NUM_IN*WIDTH  flattened sources; source k = iData[k*WIDTH +: WIDTH]
- iSel  input  SEL_W  source select, binary
- iValid  input  1  upstream beat valid
- oReady  output  1  stage can accept a beat this cycle; driven directly from a register
- iFlush  input  1  synchronous flush, e.g. on branch mispredict
- oData  output  WIDTH  registered selected data
- oErr  output  1  the beat on oData had iSel ≥ NUM_IN
- oValid  output  1  oData/oErr valid
- iReady  input  1  downstream accepts when oValid && iReady

## Operation
- A beat is accepted when iValid && oReady && !iFlush.
- Selection: data = source iSel. If iSel ≥ NUM_IN, data = source 0 and err = 1. Otherwise err = 0. err travels with its beat.
- Storage: main register (drives oData/oErr/oValid) and skid register. State is encoded as EMPTY, ONE (main full), TWO (main+skid full).
- oReady = (state != TWO).
- Transitions (no flush); "pop" = oValid && iReady:
  - EMPTY: on accept, the beat goes to main → ONE.
  - ONE: accept with pop → main reloads, stay ONE. Accept without pop → beat goes to skid → TWO. Pop without accept → EMPTY.
  - TWO: no accept is possible. On pop, skid moves to main → ONE.
- Flush: next state is EMPTY. The incoming beat is dropped. Any pop in the same cycle still counts downstream, but the register contents are discarded. Flush overrides all transitions.
- Reset mid-operation: both entries are discarded immediately, asynchronously.
- While oValid && !iReady, oData and oErr are held stable.
- Ordering is strictly FIFO. No beat is duplicated or lost, except by flush or reset.

## Timing
- Latency: a beat accepted at edge n appears on oData/oValid after edge n (1 cycle) when the stage was EMPTY or main was popping.
- Throughput: 1 beat/cycle sustained while iReady=1.
- oReady deasserts on the edge that enters TWO. It reasserts on the edge after the first pop in TWO. There is no combinational iReady→oReady path.
- Reset values (while iRst_n=0 and after release): oValid=0, oData=0, oErr=0, oReady=1, state EMPTY.
- Register contents are not cleared on pop or flush, only their valid state. oData is don't-care when oValid=0.

## Structure
- Package pipe_pkg:
  - State encoding localparams: ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
  - Default PIPE_WIDTH=32.
- Sub-module pipe_mux_sel: purely combinational NUM_IN:1 selector. Inputs iData and iSel; outputs oData and oErr, with out-of-range handling as specified above. It is reusable by non-registered users.
- pipe_mux_stage instantiates one pipe_mux_sel and holds the state register, main register and skid register.

## Test plan
- Reset: hold iRst_n=0 with iValid=1 → oValid=0, oData=0, oErr=0, oReady=1. Release, drive iSel=2, source2=32'hDEAD_BEEF → after 1 edge oData=32'hDEAD_BEEF, oValid=1.
- Streaming: iReady=1, 8 consecutive beats with iSel cycling 0..3 and sources k=32'h1000+k → outputs 32'h1000,32'h1001,32'h1002,32'h1003,… in order, one per cycle, oReady constantly 1.
- Backpressure: iReady=0 while sending beats A,B → state TWO, oReady=0 after the 2nd edge, oData=A held. Raise iReady → A, then B, each for one cycle; oReady=1 one edge after A pops; no loss or duplication.
- Out-of-range select: NUM_IN=3, iSel=2'd3, source0=32'h5 → oData=32'h5, oErr=1 for that beat only. Next beat with iSel=1 → oErr=0.
- Flush: state TWO with iValid=1, assert iFlush one cycle → next cycle oValid=0, oReady=1. The dropped beat never appears.
- Async reset mid-stream: assert iRst_n=0 between edges while in ONE → oValid falls without waiting for an edge. All outputs return to their reset values.
